// File: rtl/osc_meas_pkg.sv
// Shared types and default timing for the oscillator pair measurement sequencer.
package osc_meas_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_SETTLE,
      ST_COMPARE,
      ST_DONE
   } meas_state_t;

   localparam int DEF_CLEAR_CYCLES  = 4;
   localparam int DEF_WINDOW_CYCLES = 1024;
   localparam int DEF_SETTLE_CYCLES = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/osc_count_sel.sv
// NUM_OSC:1 selector picking one counter value out of the packed count bus.
module osc_count_sel #(
   parameter  int NUM_OSC        = 8,
   parameter  int COUNTER_LENGTH = 128,
   localparam int SEL_W          = $clog2(NUM_OSC)
) (
   input  logic [NUM_OSC*COUNTER_LENGTH-1:0] OSC_COUNT,
   input  logic [SEL_W-1:0]                  SEL,
   output logic [COUNTER_LENGTH-1:0]         COUNT
);

   always_comb begin
      COUNT = '0;
      for (int unsigned i = 0; i < NUM_OSC; i++) begin
         if (SEL == SEL_W'(i)) COUNT = OSC_COUNT[i*COUNTER_LENGTH +: COUNTER_LENGTH];
      end
   end

endmodule

// File: rtl/osc_pair_meas_ctrl.sv
// Sequencer that clears, gates and compares two ring-oscillator counters,
// returning which one ran faster and by how much.
module osc_pair_meas_ctrl
   import osc_meas_pkg::*;
#(
   parameter  int NUM_OSC        = 8,
   parameter  int COUNTER_LENGTH = 128,
   parameter  int CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
   parameter  int WINDOW_CYCLES  = DEF_WINDOW_CYCLES,
   parameter  int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   localparam int SEL_W          = $clog2(NUM_OSC)
) (
   input  logic                              CLK,
   input  logic                              RESETN,
   input  logic                              REQ_VALID,
   output logic                              REQ_READY,
   input  logic [SEL_W-1:0]                  REQ_SEL_A,
   input  logic [SEL_W-1:0]                  REQ_SEL_B,
   output logic [NUM_OSC-1:0]                OSC_RESET,
   output logic [NUM_OSC-1:0]                OSC_EN,
   input  logic [NUM_OSC*COUNTER_LENGTH-1:0] OSC_COUNT,
   output logic                              RSP_VALID,
   input  logic                              RSP_READY,
   output logic                              RSP_BIT,
   output logic                              RSP_TIE,
   output logic                              RSP_ERR,
   output logic [COUNTER_LENGTH-1:0]         RSP_DIFF
);

   localparam int PH_MAX = max3(CLEAR_CYCLES, WINDOW_CYCLES, SETTLE_CYCLES);
   localparam int PH_W   = $clog2(PH_MAX + 1);

   localparam logic [PH_W-1:0] CLEAR_LAST  = PH_W'(CLEAR_CYCLES - 1);
   localparam logic [PH_W-1:0] WINDOW_LAST = PH_W'(WINDOW_CYCLES - 1);
   localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

   meas_state_t                state;
   logic [PH_W-1:0]            phase;
   logic [SEL_W-1:0]           sel_a_q;
   logic [SEL_W-1:0]           sel_b_q;
   logic [NUM_OSC-1:0]         pair_mask;
   logic                       bad_sel;
   logic [COUNTER_LENGTH-1:0]  count_a;
   logic [COUNTER_LENGTH-1:0]  count_b;
   logic                       a_gt_b;
   logic [COUNTER_LENGTH-1:0]  abs_diff;

   osc_count_sel #(
      .NUM_OSC        (NUM_OSC),
      .COUNTER_LENGTH (COUNTER_LENGTH)
   ) u_sel_a (
      .OSC_COUNT (OSC_COUNT),
      .SEL       (sel_a_q),
      .COUNT     (count_a)
   );

   osc_count_sel #(
      .NUM_OSC        (NUM_OSC),
      .COUNTER_LENGTH (COUNTER_LENGTH)
   ) u_sel_b (
      .OSC_COUNT (OSC_COUNT),
      .SEL       (sel_b_q),
      .COUNT     (count_b)
   );

   // Non-power-of-two banks leave select codes with no oscillator behind them.
   always_comb begin
      bad_sel = (REQ_SEL_A == REQ_SEL_B)
             || (32'(REQ_SEL_A) >= 32'(NUM_OSC))
             || (32'(REQ_SEL_B) >= 32'(NUM_OSC));
   end

   always_comb begin
      pair_mask = '0;
      for (int unsigned i = 0; i < NUM_OSC; i++) begin
         if (sel_a_q == SEL_W'(i) || sel_b_q == SEL_W'(i)) pair_mask[i] = 1'b1;
      end
   end

   always_comb begin
      a_gt_b   = count_a > count_b;
      abs_diff = a_gt_b ? (count_a - count_b) : (count_b - count_a);
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state     <= ST_IDLE;
         phase     <= '0;
         sel_a_q   <= '0;
         sel_b_q   <= '0;
         REQ_READY <= 1'b0;
         OSC_RESET <= '1;
         OSC_EN    <= '0;
         RSP_VALID <= 1'b0;
         RSP_BIT   <= 1'b0;
         RSP_TIE   <= 1'b0;
         RSP_ERR   <= 1'b0;
         RSP_DIFF  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               REQ_READY <= 1'b1;
               phase     <= '0;
               if (REQ_VALID && REQ_READY) begin
                  REQ_READY <= 1'b0;
                  sel_a_q   <= REQ_SEL_A;
                  sel_b_q   <= REQ_SEL_B;
                  if (bad_sel) begin
                     state     <= ST_DONE;
                     RSP_VALID <= 1'b1;
                     RSP_ERR   <= 1'b1;
                     RSP_BIT   <= 1'b0;
                     RSP_TIE   <= 1'b0;
                     RSP_DIFF  <= '0;
                  end else begin
                     state <= ST_CLEAR;
                  end
               end
            end
            ST_CLEAR: begin
               if (phase == CLEAR_LAST) begin
                  state     <= ST_RUN;
                  phase     <= '0;
                  OSC_RESET <= ~pair_mask;
                  OSC_EN    <= pair_mask;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_RUN: begin
               if (phase == WINDOW_LAST) begin
                  state  <= ST_SETTLE;
                  phase  <= '0;
                  OSC_EN <= '0;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_SETTLE: begin
               if (phase == SETTLE_LAST) begin
                  state <= ST_COMPARE;
                  phase <= '0;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_COMPARE: begin
               state     <= ST_DONE;
               RSP_VALID <= 1'b1;
               RSP_ERR   <= 1'b0;
               RSP_BIT   <= a_gt_b;
               RSP_TIE   <= (count_a == count_b);
               RSP_DIFF  <= abs_diff;
            end
            ST_DONE: begin
               if (RSP_READY) begin
                  state     <= ST_IDLE;
                  RSP_VALID <= 1'b0;
                  REQ_READY <= 1'b1;
                  OSC_RESET <= '1;
                  OSC_EN    <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_osc_pair_meas_ctrl.sv
// Bench for osc_pair_meas_ctrl: free-running oscillator counter models on an
// 8x128 instance plus a directly driven 6x8 instance for range/wrap cases.
`timescale 1ns/1ps
module tb_osc_pair_meas_ctrl;

   localparam int N   = 8;
   localparam int CL  = 128;
   localparam int LAT = 4 + 1024 + 4 + 1;
   localparam int WIN_NS = 1024 * 10;
   localparam int SN  = 6;
   localparam int SCL = 8;
   localparam int SLAT = 2 + 8 + 2 + 1;

   logic CLK = 1'b0;
   logic RESETN = 1'b0;

   logic            REQ_VALID = 1'b0, REQ_READY, RSP_VALID, RSP_READY = 1'b0;
   logic [2:0]      REQ_SEL_A = '0, REQ_SEL_B = '0;
   logic [N-1:0]    OSC_RESET, OSC_EN;
   logic [N*CL-1:0] OSC_COUNT;
   logic            RSP_BIT, RSP_TIE, RSP_ERR;
   logic [CL-1:0]   RSP_DIFF;

   logic             sm_req_valid = 1'b0, sm_req_ready, sm_rsp_valid, sm_rsp_ready = 1'b0;
   logic [2:0]       sm_sel_a = '0, sm_sel_b = '0;
   logic [SN-1:0]    sm_osc_reset, sm_osc_en;
   logic [SN*SCL-1:0] sm_count = '0;
   logic             sm_bit, sm_tie, sm_err;
   logic [SCL-1:0]   sm_diff;

   int checks = 0;
   int errors = 0;

   logic [CL-1:0] mcnt [N];
   int            per  [N];

   always #5 CLK = ~CLK;

   osc_pair_meas_ctrl #(
      .NUM_OSC(N), .COUNTER_LENGTH(CL), .CLEAR_CYCLES(4), .WINDOW_CYCLES(1024), .SETTLE_CYCLES(4)
   ) u_dut (
      .CLK(CLK), .RESETN(RESETN), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_SEL_A(REQ_SEL_A), .REQ_SEL_B(REQ_SEL_B), .OSC_RESET(OSC_RESET), .OSC_EN(OSC_EN),
      .OSC_COUNT(OSC_COUNT), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_BIT(RSP_BIT),
      .RSP_TIE(RSP_TIE), .RSP_ERR(RSP_ERR), .RSP_DIFF(RSP_DIFF)
   );

   osc_pair_meas_ctrl #(
      .NUM_OSC(SN), .COUNTER_LENGTH(SCL), .CLEAR_CYCLES(2), .WINDOW_CYCLES(8), .SETTLE_CYCLES(2)
   ) u_small (
      .CLK(CLK), .RESETN(RESETN), .REQ_VALID(sm_req_valid), .REQ_READY(sm_req_ready),
      .REQ_SEL_A(sm_sel_a), .REQ_SEL_B(sm_sel_b), .OSC_RESET(sm_osc_reset), .OSC_EN(sm_osc_en),
      .OSC_COUNT(sm_count), .RSP_VALID(sm_rsp_valid), .RSP_READY(sm_rsp_ready), .RSP_BIT(sm_bit),
      .RSP_TIE(sm_tie), .RSP_ERR(sm_err), .RSP_DIFF(sm_diff)
   );

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign OSC_COUNT[g*CL +: CL] = mcnt[g];
   end

   // Oscillators tick on a shared 1 ns grid offset by 0.5 ns from clock edges;
   // osc i ticks every per[i] grid steps while enabled and out of reset.
   initial begin : osc_model
      int t;
      t = 0;
      for (int i = 0; i < N; i++) mcnt[i] = '0;
      #0.5;
      forever begin
         t++;
         for (int i = 0; i < N; i++) begin
            if (OSC_RESET[i]) mcnt[i] = '0;
            else if (OSC_EN[i] && per[i] > 0 && (t % per[i]) == 0) mcnt[i] = mcnt[i] + 1'b1;
         end
         #1;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] absdiff(input logic [127:0] a, input logic [127:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic main_req(input int a, input int b);
      REQ_SEL_A = 3'(a);
      REQ_SEL_B = 3'(b);
      REQ_VALID = 1'b1;
      for (int k = 0; k < 100 && !REQ_READY; k++) tick();
      chk("req_ready_pre", 128'(REQ_READY), 128'(1));
      tick();
      REQ_VALID = 1'b0;
      REQ_SEL_A = 3'($urandom_range(0, 7));
      REQ_SEL_B = 3'($urandom_range(0, 7));
      chk("req_ready_busy", 128'(REQ_READY), 128'(0));
   endtask

   task automatic main_wait(output int lat, output logic [N-1:0] en, output logic [N-1:0] rl);
      lat = 0;
      en  = '0;
      rl  = '0;
      while (lat < 5000) begin
         tick();
         lat++;
         en |= OSC_EN;
         rl |= ~OSC_RESET;
         if (RSP_VALID) break;
      end
   endtask

   task automatic main_check(input int a, input int b, input int lat,
                             input logic [N-1:0] en, input logic [N-1:0] rl);
      logic           err;
      logic [N-1:0]   mask;
      logic [127:0]   ea, eb;
      err  = (a == b);
      mask = err ? '0 : ((N'(1) << a) | (N'(1) << b));
      chk("latency", 128'(lat), err ? 128'(1) : 128'(LAT));
      chk("en_pair", 128'(en), 128'(mask));
      chk("rst_pair", 128'(rl), 128'(mask));
      chk("rsp_err", 128'(RSP_ERR), 128'(err));
      if (err) begin
         chk("err_bit", 128'(RSP_BIT), 128'(0));
         chk("err_tie", 128'(RSP_TIE), 128'(0));
         chk("err_diff", 128'(RSP_DIFF), 128'(0));
      end else begin
         ea = mcnt[a];
         eb = mcnt[b];
         chk("rsp_bit", 128'(RSP_BIT), 128'(ea > eb));
         chk("rsp_tie", 128'(RSP_TIE), 128'(ea == eb));
         chk("rsp_diff", 128'(RSP_DIFF), absdiff(ea, eb));
         chk("window_a", 128'(ea + 1 >= 128'(WIN_NS / per[a]) && ea <= 128'(WIN_NS / per[a] + 1)), 128'(1));
      end
   endtask

   task automatic main_ack();
      RSP_READY = 1'b1;
      tick();
      RSP_READY = 1'b0;
      chk("rsp_drop", 128'(RSP_VALID), 128'(0));
      chk("ready_back", 128'(REQ_READY), 128'(1));
      chk("rst_all", 128'(OSC_RESET), 128'({N{1'b1}}));
   endtask

   task automatic main_txn(input int a, input int b, input int hold);
      int lat;
      logic [N-1:0] en, rl;
      main_req(a, b);
      main_wait(lat, en, rl);
      main_check(a, b, lat, en, rl);
      repeat (hold) tick();
      chk("hold_valid", 128'(RSP_VALID), 128'(1));
      main_ack();
   endtask

   task automatic sm_txn(input int a, input int b, input logic [7:0] ca, input logic [7:0] cb);
      int lat;
      logic err;
      logic [SN-1:0] en;
      sm_count = '0;
      if (a < SN) sm_count[a*SCL +: SCL] = ca;
      if (b < SN) sm_count[b*SCL +: SCL] = cb;
      err = (a == b) || (a >= SN) || (b >= SN);
      sm_sel_a = 3'(a);
      sm_sel_b = 3'(b);
      sm_req_valid = 1'b1;
      for (int k = 0; k < 100 && !sm_req_ready; k++) tick();
      chk("sm_ready_pre", 128'(sm_req_ready), 128'(1));
      tick();
      sm_req_valid = 1'b0;
      lat = 0;
      en  = '0;
      while (lat < 200) begin
         tick();
         lat++;
         en |= sm_osc_en;
         if (sm_rsp_valid) break;
      end
      chk("sm_latency", 128'(lat), err ? 128'(1) : 128'(SLAT));
      chk("sm_en", 128'(en), err ? 128'(0) : 128'((SN'(1) << a) | (SN'(1) << b)));
      chk("sm_err", 128'(sm_err), 128'(err));
      chk("sm_bit", 128'(sm_bit), err ? 128'(0) : 128'(ca > cb));
      chk("sm_tie", 128'(sm_tie), err ? 128'(0) : 128'(ca == cb));
      chk("sm_diff", 128'(sm_diff), err ? 128'(0) : absdiff(128'(ca), 128'(cb)));
      sm_rsp_ready = 1'b1;
      tick();
      sm_rsp_ready = 1'b0;
      chk("sm_drop", 128'(sm_rsp_valid), 128'(0));
   endtask

   initial begin : stim
      int lat, a, b;
      logic [N-1:0] en, rl;
      logic [127:0] exp_diff;
      for (int i = 0; i < N; i++) per[i] = 3;

      // Reset values while RESETN is held low
      #12;
      chk("rst_req_ready", 128'(REQ_READY), 128'(0));
      chk("rst_osc_reset", 128'(OSC_RESET), 128'({N{1'b1}}));
      chk("rst_osc_en", 128'(OSC_EN), 128'(0));
      chk("rst_rsp", 128'({RSP_VALID, RSP_BIT, RSP_TIE, RSP_ERR}), 128'(0));
      chk("rst_diff", 128'(RSP_DIFF), 128'(0));
      RESETN = 1'b1;
      tick();
      tick();
      chk("idle_ready", 128'(REQ_READY), 128'(1));

      // Nominal: osc 2 faster than osc 5
      per[2] = 3;
      per[5] = 4;
      main_req(2, 5);
      main_wait(lat, en, rl);
      main_check(2, 5, lat, en, rl);
      chk("nom_bit", 128'(RSP_BIT), 128'(1));
      chk("nom_tie", 128'(RSP_TIE), 128'(0));
      main_ack();

      // Equal periods on 0 and 1 must tie
      per[0] = 5;
      per[1] = 5;
      main_req(0, 1);
      main_wait(lat, en, rl);
      main_check(0, 1, lat, en, rl);
      chk("eq_tie", 128'(RSP_TIE), 128'(1));
      chk("eq_diff", 128'(RSP_DIFF), 128'(0));
      main_ack();

      // Same select on both sides
      main_txn(3, 3, 2);

      // Backpressure: response held, next request waits for the handshake
      per[2] = 3;
      per[5] = 4;
      main_req(2, 5);
      main_wait(lat, en, rl);
      main_check(2, 5, lat, en, rl);
      exp_diff = absdiff(mcnt[2], mcnt[5]);
      per[1] = 2;
      per[6] = 7;
      REQ_SEL_A = 3'd1;
      REQ_SEL_B = 3'd6;
      REQ_VALID = 1'b1;
      for (int k = 0; k < 50; k++) begin
         tick();
         chk("bp_valid", 128'(RSP_VALID), 128'(1));
         chk("bp_req_ready", 128'(REQ_READY), 128'(0));
         chk("bp_diff", 128'(RSP_DIFF), exp_diff);
         chk("bp_bit", 128'(RSP_BIT), 128'(1));
      end
      main_ack();
      tick();
      chk("bp_accept", 128'(REQ_READY), 128'(0));
      REQ_VALID = 1'b0;
      main_wait(lat, en, rl);
      main_check(1, 6, lat, en, rl);
      main_ack();

      // Reset asserted mid-window
      main_req(3, 6);
      repeat (500) tick();
      chk("run_en", 128'(OSC_EN), 128'(8'h48));
      RESETN = 1'b0;
      #1;
      chk("mid_rst_en", 128'(OSC_EN), 128'(0));
      chk("mid_rst_reset", 128'(OSC_RESET), 128'({N{1'b1}}));
      chk("mid_rst_valid", 128'(RSP_VALID), 128'(0));
      chk("mid_rst_ready", 128'(REQ_READY), 128'(0));
      tick();
      RESETN = 1'b1;
      tick();
      chk("post_rst_ready", 128'(REQ_READY), 128'(1));

      // Randomized pairs and periods
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) per[i] = int'($urandom_range(2, 9));
         a = int'($urandom_range(0, N - 1));
         b = (r == 3) ? a : int'($urandom_range(0, N - 1));
         main_txn(a, b, int'($urandom_range(0, 5)));
      end

      // Narrow instance: full-scale difference, out-of-range select, random counts
      sm_txn(0, 1, 8'd255, 8'd0);
      sm_txn(0, 1, 8'd0, 8'd255);
      sm_txn(7, 2, 8'd10, 8'd20);
      sm_txn(4, 4, 8'd10, 8'd20);
      for (int r = 0; r < 4; r++) begin
         sm_txn(int'($urandom_range(0, SN - 1)), int'($urandom_range(0, 7)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
